cart_bus_master: RTL and testbench
==================================

CART_BUS_MASTER -- requirements
Module: cart_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the WAIT-state cycle limit before timeout (range 1..65535).
REQ-002 SHALL have port i_clk  input  1  clock; all logic is rising-edge.
REQ-003 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_cmd_valid  input  1  command present.
REQ-005 SHALL have port o_cmd_ready  output  1  command accepted when high together with i_cmd_valid.
REQ-006 SHALL have port i_cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports i_cmd_address  input  32 and i_cmd_data  input  32, carrying command address and write data.
REQ-008 SHALL have port o_rsp_valid  output  1  response present.
REQ-009 SHALL have port i_rsp_ready  input  1  response consumed when high together with o_rsp_valid.
REQ-010 SHALL have ports o_rsp_data  output  32 (read data) and o_rsp_timeout  output  1 (transaction timed out).
REQ-011 SHALL have bus ports o_select  output  1, o_read_rq  output  1, o_write_rq  output  1, i_ack  input  1, o_address  output  32, o_data  output  32, i_data  input  32.
REQ-012 SHALL have port o_busy  output  1, high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, REQUEST, WAIT, RESPOND; one transaction outstanding at a time.
REQ-014 IDLE: o_cmd_ready=1; on i_cmd_valid, latch write/address/data and go to REQUEST next cycle.
REQ-015 REQUEST (exactly one cycle): o_select=1; o_read_rq=!write; o_write_rq=write; then go to WAIT.
REQ-016 o_read_rq/o_write_rq SHALL be high only in REQUEST, never both.
REQ-017 o_select SHALL be high in REQUEST and WAIT only; o_address/o_data SHALL hold latched values from REQUEST through RESPOND.
REQ-018 WAIT: on i_ack=1, capture i_data into o_rsp_data for reads (0 for writes), clear o_rsp_timeout, go to RESPOND.
REQ-019 i_ack SHALL be ignored in IDLE, REQUEST and RESPOND.
REQ-020 Minimum latency: command accepted cycle N, request N+1, ack at N+2 gives o_rsp_valid at N+3.
REQ-021 RESPOND: o_rsp_valid=1, data/timeout stable; on i_rsp_ready go to IDLE next cycle; o_cmd_ready SHALL stay 0 in RESPOND.
REQ-022 Back-to-back: a command already valid in IDLE SHALL be accepted in the first IDLE cycle (one idle cycle between transactions).
REQ-023 Timeout counter (16-bit): cleared on entry to WAIT, incremented per WAIT cycle without ack; when it equals TIMEOUT_CYCLES-1 without ack, go to RESPOND with o_rsp_timeout=1, o_rsp_data=0.
REQ-024 Ack in the same cycle as timeout expiry SHALL win (normal response, timeout=0).

Reset
REQ-025 i_reset SHALL asynchronously force IDLE, counter 0, and all outputs to 0 except o_cmd_ready=1 once reset deasserts.
REQ-026 Reset mid-transaction SHALL abandon it without a response; o_select/rq drop immediately.

Configuration
REQ-027 Macro CART_BUS_MASTER_TIMEOUT_EN defined: timeout logic per REQ-023/024 present.
REQ-028 Macro undefined: no counter; WAIT lasts until i_ack indefinitely; o_rsp_timeout tied 0; TIMEOUT_CYCLES unused.

Verification
REQ-029 Write cmd addr 0x0, data 0x2, responder acks next cycle -> one-cycle o_write_rq, o_address=0x0, o_data=0x2, o_rsp_valid 3 cycles after accept, timeout=0.
REQ-030 Read cmd addr 0x4, responder returns 0x000000A5 -> o_rsp_data=0x000000A5, o_read_rq single cycle.
REQ-031 Responder never acks, TIMEOUT_CYCLES=8, macro defined -> o_rsp_valid with o_rsp_timeout=1, data 0, after 8 WAIT cycles; macro undefined -> o_busy stays 1.
REQ-032 Hold i_rsp_ready=0 for 5 cycles -> response stable, o_cmd_ready=0, no new rq; then release -> IDLE, next command accepted.
REQ-033 Assert i_reset during WAIT -> all bus outputs 0 asynchronously, no response, next read succeeds normally.
REQ-034 Ack coincident with timeout expiry -> normal read data, o_rsp_timeout=0.

Source files
------------

// File: rtl/cart_bus_master.sv
// Single-outstanding command-to-bus master: IDLE -> REQUEST -> WAIT -> RESPOND.
// Define CART_BUS_MASTER_TIMEOUT_EN to add the WAIT-state timeout.

module cart_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [31:0] i_cmd_address,
    input  logic [31:0] i_cmd_data,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_timeout,
    output logic        o_select,
    output logic        o_read_rq,
    output logic        o_write_rq,
    input  logic        i_ack,
    output logic [31:0] o_address,
    output logic [31:0] o_data,
    input  logic [31:0] i_data,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_WAIT,
        ST_RESPOND
    } state_t;

    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        write_q, write_d;
    logic        select_q, select_d;
    logic        read_rq_q, read_rq_d;
    logic        write_rq_q, write_rq_d;
    logic [31:0] address_q, address_d;
    logic [31:0] data_q, data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("cart_bus_master: TIMEOUT_CYCLES must be in 1..65535");
    end

`ifdef CART_BUS_MASTER_TIMEOUT_EN
    localparam logic [15:0] COUNT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] count_q, count_d;
    logic        rsp_timeout_q, rsp_timeout_d;
`endif

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case can infer a latch.
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        write_d     = write_q;
        select_d    = select_q;
        read_rq_d   = read_rq_q;
        write_rq_d  = write_rq_q;
        address_d   = address_q;
        data_d      = data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
`ifdef CART_BUS_MASTER_TIMEOUT_EN
        count_d       = count_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    write_d     = i_cmd_write;
                    address_d   = i_cmd_address;
                    data_d      = i_cmd_data;
                    cmd_ready_d = 1'b0;
                    select_d    = 1'b1;
                    read_rq_d   = !i_cmd_write;
                    write_rq_d  = i_cmd_write;
                    state_d     = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                read_rq_d  = 1'b0;
                write_rq_d = 1'b0;
                state_d    = ST_WAIT;
`ifdef CART_BUS_MASTER_TIMEOUT_EN
                count_d = 16'd0;
`endif
            end
            ST_WAIT: begin
                // Ack is checked first so it wins over an expiry in the same cycle.
                if (i_ack) begin
                    rsp_data_d  = write_q ? 32'd0 : i_data;
                    rsp_valid_d = 1'b1;
                    select_d    = 1'b0;
                    state_d     = ST_RESPOND;
`ifdef CART_BUS_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (count_q == COUNT_LAST) begin
                    rsp_data_d    = 32'd0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    select_d      = 1'b0;
                    state_d       = ST_RESPOND;
                end else begin
                    count_d = count_q + 16'd1;
`endif
                end
            end
            ST_RESPOND: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        // NOTE: reset clears every flop, data registers included, so no stale value survives an abandoned transaction.
        if (i_reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            write_q     <= 1'b0;
            select_q    <= 1'b0;
            read_rq_q   <= 1'b0;
            write_rq_q  <= 1'b0;
            address_q   <= 32'd0;
            data_q      <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
`ifdef CART_BUS_MASTER_TIMEOUT_EN
            count_q       <= 16'd0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            write_q     <= write_d;
            select_q    <= select_d;
            read_rq_q   <= read_rq_d;
            write_rq_q  <= write_rq_d;
            address_q   <= address_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef CART_BUS_MASTER_TIMEOUT_EN
            count_q       <= count_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_select    = select_q;
    assign o_read_rq   = read_rq_q;
    assign o_write_rq  = write_rq_q;
    assign o_address   = address_q;
    assign o_data      = data_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_busy      = (state_q != ST_IDLE);
`ifdef CART_BUS_MASTER_TIMEOUT_EN
    assign o_rsp_timeout = rsp_timeout_q;
`else
    assign o_rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cart_bus_master.sv
// Directed self-checking bench for cart_bus_master (TIMEOUT_CYCLES = 8).
// Control vector order in checks: {select, read_rq, write_rq, rsp_valid, busy, cmd_ready}.

module tb_cart_bus_master;

    localparam int unsigned TIMEOUT = 8;

    logic        i_clk;
    logic        i_reset;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_write;
    logic [31:0] i_cmd_address;
    logic [31:0] i_cmd_data;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic        o_rsp_timeout;
    logic        o_select;
    logic        o_read_rq;
    logic        o_write_rq;
    logic        i_ack;
    logic [31:0] o_address;
    logic [31:0] o_data;
    logic [31:0] i_data;
    logic        o_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    cart_bus_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_write   (i_cmd_write),
        .i_cmd_address (i_cmd_address),
        .i_cmd_data    (i_cmd_data),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_timeout (o_rsp_timeout),
        .o_select      (o_select),
        .o_read_rq     (o_read_rq),
        .o_write_rq    (o_write_rq),
        .i_ack         (i_ack),
        .o_address     (o_address),
        .o_data        (o_data),
        .i_data        (i_data),
        .o_busy        (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [5:0] ctl();
        return {o_select, o_read_rq, o_write_rq, o_rsp_valid, o_busy, o_cmd_ready};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present a command for one edge; on return the DUT is in REQUEST.
    task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        i_cmd_valid   = 1'b1;
        i_cmd_write   = wr;
        i_cmd_address = addr;
        i_cmd_data    = data;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic consume_rsp();
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_address = '0; i_cmd_data = '0;
        i_rsp_ready = 1'b0; i_ack = 1'b0; i_data = '0;
        #12;
        tests_run++;
        if ({o_select, o_read_rq, o_write_rq, o_rsp_valid, o_busy} !== 5'b00000) begin
            tests_failed++;
            $display("FAIL reset_held_outputs: got %b expected 00000", {o_select, o_read_rq, o_write_rq, o_rsp_valid, o_busy});
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        tick();
        tests_run++;
        if (ctl() !== 6'b000001 || o_rsp_timeout !== 1'b0 || o_rsp_data !== 32'd0 || o_address !== 32'd0 || o_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_idle: ctl got %b expected 000001, tmo=%b data=%h addr=%h wdata=%h expected zeros",
                     ctl(), o_rsp_timeout, o_rsp_data, o_address, o_data);
        end
        i_ack = 1'b1; i_data = 32'h1111_2222;
        tick();
        i_ack = 1'b0;
        tests_run++;
        if (ctl() !== 6'b000001 || o_rsp_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL idle_ack_ignored: ctl got %b expected 000001, data got %h expected 0", ctl(), o_rsp_data);
        end
    endtask

    task automatic test_write();
        drive_cmd(1'b1, 32'h0, 32'h2);
        tests_run++;
        if (ctl() !== 6'b101010 || o_address !== 32'h0 || o_data !== 32'h2) begin
            tests_failed++;
            $display("FAIL write_request: ctl got %b expected 101010, addr=%h data=%h expected 0/2", ctl(), o_address, o_data);
        end
        tick();
        tests_run++;
        if (ctl() !== 6'b100010) begin
            tests_failed++;
            $display("FAIL write_rq_single_cycle: ctl got %b expected 100010", ctl());
        end
        i_ack = 1'b1; i_data = 32'hFFFF_FFFF;
        tick();
        i_ack = 1'b0;
        tests_run++;
        if (ctl() !== 6'b000110 || o_rsp_data !== 32'd0 || o_rsp_timeout !== 1'b0 || o_address !== 32'h0 || o_data !== 32'h2) begin
            tests_failed++;
            $display("FAIL write_response: ctl got %b expected 000110, data=%h tmo=%b addr=%h wdata=%h expected 0/0/0/2",
                     ctl(), o_rsp_data, o_rsp_timeout, o_address, o_data);
        end
        consume_rsp();
        tests_run++;
        if (ctl() !== 6'b000001) begin
            tests_failed++;
            $display("FAIL write_back_to_idle: ctl got %b expected 000001", ctl());
        end
    endtask

    task automatic test_read();
        drive_cmd(1'b0, 32'h4, 32'h1234_5678);
        tests_run++;
        if (ctl() !== 6'b110010 || o_address !== 32'h4) begin
            tests_failed++;
            $display("FAIL read_request: ctl got %b expected 110010, addr got %h expected 4", ctl(), o_address);
        end
        i_ack = 1'b1; i_data = 32'hDEAD_BEEF;
        tick();
        i_ack = 1'b0;
        tests_run++;
        if (ctl() !== 6'b100010) begin
            tests_failed++;
            $display("FAIL read_request_ack_ignored: ctl got %b expected 100010", ctl());
        end
        tick();
        tests_run++;
        if (ctl() !== 6'b100010) begin
            tests_failed++;
            $display("FAIL read_still_waiting: ctl got %b expected 100010", ctl());
        end
        i_ack = 1'b1; i_data = 32'h0000_00A5;
        tick();
        tests_run++;
        if (ctl() !== 6'b000110 || o_rsp_data !== 32'h0000_00A5 || o_rsp_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_response: ctl got %b expected 000110, data got %h expected 000000a5, tmo=%b", ctl(), o_rsp_data, o_rsp_timeout);
        end
        i_data = 32'h0000_0077;
        tick();
        i_ack = 1'b0;
        tests_run++;
        if (ctl() !== 6'b000110 || o_rsp_data !== 32'h0000_00A5) begin
            tests_failed++;
            $display("FAIL respond_ack_ignored: ctl got %b expected 000110, data got %h expected 000000a5", ctl(), o_rsp_data);
        end
        consume_rsp();
    endtask

    task automatic test_timeout();
        logic early;
        early = 1'b0;
        drive_cmd(1'b0, 32'h8, 32'h0);
        tick();
        for (int k = 0; k < 8; k++) begin
            if (o_rsp_valid !== 1'b0 || o_select !== 1'b1) early = 1'b1;
            tick();
        end
        tests_run++;
        if (early !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_wait_cycles: early exit from WAIT got %b expected 0", early);
        end
`ifdef CART_BUS_MASTER_TIMEOUT_EN
        tests_run++;
        if (ctl() !== 6'b000110 || o_rsp_timeout !== 1'b1 || o_rsp_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL timeout_response: ctl got %b expected 000110, tmo got %b expected 1, data got %h expected 0",
                     ctl(), o_rsp_timeout, o_rsp_data);
        end
`else
        tick(); tick(); tick();
        tests_run++;
        if (ctl() !== 6'b100010 || o_rsp_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_timeout_busy: ctl got %b expected 100010, tmo got %b expected 0", ctl(), o_rsp_timeout);
        end
        i_ack = 1'b1; i_data = 32'h0;
        tick();
        i_ack = 1'b0;
`endif
        consume_rsp();
    endtask

    task automatic test_ack_at_expiry();
        drive_cmd(1'b0, 32'hC, 32'h0);
        tick();
        for (int k = 0; k < 7; k++) tick();
        tests_run++;
        if (ctl() !== 6'b100010) begin
            tests_failed++;
            $display("FAIL expiry_last_wait_cycle: ctl got %b expected 100010", ctl());
        end
        i_ack = 1'b1; i_data = 32'h5A5A_1234;
        tick();
        i_ack = 1'b0;
        tests_run++;
        if (ctl() !== 6'b000110 || o_rsp_data !== 32'h5A5A_1234 || o_rsp_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL ack_wins_expiry: ctl got %b expected 000110, data got %h expected 5a5a1234, tmo got %b expected 0",
                     ctl(), o_rsp_data, o_rsp_timeout);
        end
        consume_rsp();
    endtask

    task automatic test_back_to_back();
        drive_cmd(1'b1, 32'h10, 32'hCAFE_0001);
        tick();
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_address = 32'h20; i_cmd_data = 32'h0;
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (ctl() !== 6'b000110 || o_rsp_data !== 32'd0 || o_rsp_timeout !== 1'b0 || o_address !== 32'h10) begin
                tests_failed++;
                $display("FAIL backpressure_hold[%0d]: ctl got %b expected 000110, data=%h tmo=%b addr=%h expected 0/0/10",
                         k, ctl(), o_rsp_data, o_rsp_timeout, o_address);
            end
            tick();
        end
        consume_rsp();
        tests_run++;
        if (ctl() !== 6'b000001) begin
            tests_failed++;
            $display("FAIL backpressure_release: ctl got %b expected 000001", ctl());
        end
        tick();
        i_cmd_valid = 1'b0;
        tests_run++;
        if (ctl() !== 6'b110010 || o_address !== 32'h20) begin
            tests_failed++;
            $display("FAIL back_to_back_accept: ctl got %b expected 110010, addr got %h expected 20", ctl(), o_address);
        end
        tick();
        i_ack = 1'b1; i_data = 32'h0000_0099;
        tick();
        i_ack = 1'b0;
        tests_run++;
        if (ctl() !== 6'b000110 || o_rsp_data !== 32'h0000_0099) begin
            tests_failed++;
            $display("FAIL back_to_back_response: ctl got %b expected 000110, data got %h expected 00000099", ctl(), o_rsp_data);
        end
        consume_rsp();
    endtask

    task automatic test_reset_mid();
        drive_cmd(1'b0, 32'h30, 32'h0);
        tick();
        #2;
        i_reset = 1'b1;
        #1;
        tests_run++;
        if (ctl() !== 6'b000001 || o_address !== 32'd0 || o_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL async_reset_drop: ctl got %b expected 000001, addr=%h data=%h expected 0", ctl(), o_address, o_data);
        end
        i_ack = 1'b1; i_data = 32'h3333_3333;
        tick();
        @(negedge i_clk);
        i_reset = 1'b0;
        i_ack = 1'b0;
        tick();
        tests_run++;
        if (ctl() !== 6'b000001 || o_rsp_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_no_response: ctl got %b expected 000001, data got %h expected 0", ctl(), o_rsp_data);
        end
        drive_cmd(1'b0, 32'h40, 32'h0);
        tick();
        i_ack = 1'b1; i_data = 32'h0BAD_F00D;
        tick();
        i_ack = 1'b0;
        tests_run++;
        if (ctl() !== 6'b000110 || o_rsp_data !== 32'h0BAD_F00D || o_rsp_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_after_reset: ctl got %b expected 000110, data got %h expected 0badf00d, tmo=%b",
                     ctl(), o_rsp_data, o_rsp_timeout);
        end
        consume_rsp();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_at_expiry();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
